// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
package dmem_pkg;

   // Access size encoding as presented by both requesters.
   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   // Arbiter state: which port received the most recent grant.
   typedef enum logic {
      LAST_P0 = 1'b0,
      LAST_P1 = 1'b1
   } last_e;

   localparam int NUM_PORTS = 2;
   localparam int NUM_LANES = 4;

endpackage

// File: rtl/dmem_lane_steer.sv
// Byte-lane steering for one access: byte enables, replicated store data,
// alignment check and sign/zero extension of the addressed load lane(s).
module dmem_lane_steer
   import dmem_pkg::*;
(
   input  logic [1:0]           size_i,
   input  logic [1:0]           offset_i,
   input  logic                 unsigned_i,
   input  logic [31:0]          wdata_i,
   input  logic [31:0]          rdata_i,
   output logic [NUM_LANES-1:0] be_o,
   output logic [31:0]          wdata_o,
   output logic                 misaligned_o,
   output logic [31:0]          rdata_o
);

   size_e       size;
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   assign size = size_e'(size_i);

   // Decode size/offset into lane enables, steered data and extended load data.
   always_comb begin
      be_o         = '0;
      wdata_o      = '0;
      misaligned_o = 1'b0;
      rdata_o      = '0;
      byte_v       = 8'(rdata_i >> {offset_i, 3'b000});
      half_v       = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (size)
         SZ_BYTE: begin
            be_o    = 4'b0001 << offset_i;
            wdata_o = {4{wdata_i[7:0]}};
            rdata_o = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
         end
         SZ_HALF: begin
            misaligned_o = offset_i[0];
            be_o         = offset_i[1] ? 4'b1100 : 4'b0011;
            wdata_o      = {2{wdata_i[15:0]}};
            rdata_o      = {{16{half_v[15] & ~unsigned_i}}, half_v};
         end
         SZ_WORD: begin
            misaligned_o = |offset_i;
            be_o         = 4'b1111;
            wdata_o      = wdata_i;
            rdata_o      = rdata_i;
         end
         default: begin
            misaligned_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported byte-addressed data memory.
// Handshake: a request transfers in the cycle where req_valid_i[p] and
// req_ready_o[p] are both high; the requester holds its request stable until
// then. The response pulses rsp_valid_o[p] for one cycle, one cycle after
// acceptance, and cannot be back-pressured.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int FIXED_PRIO   = 0,
   parameter int STARVE_LIMIT = 8
) (
   input  logic                                 clk_i,
   input  logic                                 rst_n_i,
   input  logic [NUM_PORTS-1:0]                 req_valid_i,
   output logic [NUM_PORTS-1:0]                 req_ready_o,
   input  logic [NUM_PORTS-1:0]                 req_we_i,
   input  logic [NUM_PORTS-1:0][1:0]            req_size_i,
   input  logic [NUM_PORTS-1:0]                 req_unsigned_i,
   input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wdata_i,
   output logic [NUM_PORTS-1:0]                 rsp_valid_o,
   output logic                                 rsp_err_o,
   output logic [DATA_WIDTH-1:0]                rsp_rdata_o,
   output logic                                 mem_en_o,
   output logic                                 mem_wen_o,
   output logic [ADDR_WIDTH-1:0]                mem_addr_o,
   output logic [NUM_LANES-1:0]                 mem_be_o,
   output logic [DATA_WIDTH-1:0]                mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]                mem_rdata_i,
   output logic                                 dbg_last_grant_o
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   last_e                  last_q, last_d;
   logic [CNT_W-1:0]       starve_q, starve_d;
   logic                   grant_valid;
   logic                   grant_idx;
   logic                   sel_we;
   logic [1:0]             sel_size;
   logic                   sel_unsigned;
   logic [ADDR_WIDTH-1:0]  sel_addr;
   logic [DATA_WIDTH-1:0]  sel_wdata;
   logic [NUM_LANES-1:0]   be;
   logic [DATA_WIDTH-1:0]  steer_wdata;
   logic [DATA_WIDTH-1:0]  ext_rdata;
   logic                   misaligned;
   logic [NUM_PORTS-1:0]   rsp_valid_q;
   logic                   rsp_err_q;
   logic [DATA_WIDTH-1:0]  rsp_rdata_q;

   // Grant selection plus next-state of last-grant and starvation counter.
   always_comb begin
      grant_valid = rst_n_i & (|req_valid_i);
      grant_idx   = req_valid_i[1];
      if (req_valid_i == 2'b11) begin
         if (FIXED_PRIO != 0) grant_idx = (starve_q == CNT_W'(STARVE_LIMIT));
         else                 grant_idx = (last_q == LAST_P0);
      end
      req_ready_o = '0;
      if (grant_valid) req_ready_o[grant_idx] = 1'b1;
      last_d = last_q;
      if (grant_valid) last_d = last_e'(grant_idx);
      starve_d = '0;
      if (req_valid_i[1] && !(grant_valid && grant_idx))
         starve_d = (starve_q == CNT_W'(STARVE_LIMIT)) ? starve_q : starve_q + CNT_W'(1);
   end

   assign sel_we       = req_we_i[grant_idx];
   assign sel_size     = req_size_i[grant_idx];
   assign sel_unsigned = req_unsigned_i[grant_idx];
   assign sel_addr     = req_addr_i[grant_idx];
   assign sel_wdata    = req_wdata_i[grant_idx];

   dmem_lane_steer u_steer (
      .size_i       (sel_size),
      .offset_i     (sel_addr[1:0]),
      .unsigned_i   (sel_unsigned),
      .wdata_i      (sel_wdata),
      .rdata_i      (mem_rdata_i),
      .be_o         (be),
      .wdata_o      (steer_wdata),
      .misaligned_o (misaligned),
      .rdata_o      (ext_rdata)
   );

   // Errored accesses never reach memory; idle cycles drive no enables.
   assign mem_en_o    = grant_valid & ~misaligned;
   assign mem_wen_o   = mem_en_o & sel_we;
   assign mem_be_o    = mem_en_o ? be : '0;
   assign mem_addr_o  = {sel_addr[ADDR_WIDTH-1:2], 2'b00};
   assign mem_wdata_o = steer_wdata;

   // Arbiter state register; port 0 wins the first tie after reset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         last_q   <= LAST_P1;
         starve_q <= '0;
      end else begin
         last_q   <= last_d;
         starve_q <= starve_d;
      end
   end

   // Response registers; load data only updates on a grant and holds otherwise.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= req_ready_o;
         rsp_err_q   <= grant_valid & misaligned;
         if (grant_valid) rsp_rdata_q <= (!sel_we && !misaligned) ? ext_rdata : '0;
      end
   end

   // A response still in flight when reset asserts is suppressed immediately.
   assign rsp_valid_o      = rsp_valid_q & {NUM_PORTS{rst_n_i}};
   assign rsp_err_o        = rsp_err_q;
   assign rsp_rdata_o      = rsp_rdata_q;
   assign dbg_last_grant_o = last_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
   import dmem_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // ---------------- round-robin DUT signals ----------------
   logic [1:0]       req_valid, req_we, req_unsigned, req_ready, rsp_valid;
   logic [1:0][1:0]  req_size;
   logic [1:0][31:0] req_addr, req_wdata;
   logic             rsp_err, mem_en, mem_wen, dbg_last;
   logic [31:0]      rsp_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [3:0]       mem_be;
   logic [31:0]      mem [0:255];

   // ---------------- fixed-priority DUT signals ----------------
   logic [1:0]       fp_valid, fp_ready, fp_rsp_valid;
   logic [1:0]       fp_we = 2'b00, fp_uns = 2'b00;
   logic [1:0][1:0]  fp_size = {2'b10, 2'b10};
   logic [1:0][31:0] fp_addr = '0, fp_wdata = '0;
   logic [31:0]      fp_mem_rdata = 32'h0;
   logic             fp_rsp_err, fp_mem_en, fp_mem_wen, fp_dbg;
   logic [31:0]      fp_rsp_rdata, fp_mem_addr, fp_mem_wdata;
   logic [3:0]       fp_mem_be;

   int n_checks = 0;
   int n_fail   = 0;

   dmem_arbiter #(.FIXED_PRIO(0)) dut (
      .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid),
      .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata), .mem_en_o(mem_en), .mem_wen_o(mem_wen),
      .mem_addr_o(mem_addr), .mem_be_o(mem_be), .mem_wdata_o(mem_wdata),
      .mem_rdata_i(mem_rdata), .dbg_last_grant_o(dbg_last)
   );

   dmem_arbiter #(.FIXED_PRIO(1), .STARVE_LIMIT(8)) dut_fp (
      .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(fp_valid), .req_ready_o(fp_ready),
      .req_we_i(fp_we), .req_size_i(fp_size), .req_unsigned_i(fp_uns),
      .req_addr_i(fp_addr), .req_wdata_i(fp_wdata), .rsp_valid_o(fp_rsp_valid),
      .rsp_err_o(fp_rsp_err), .rsp_rdata_o(fp_rsp_rdata), .mem_en_o(fp_mem_en),
      .mem_wen_o(fp_mem_wen), .mem_addr_o(fp_mem_addr), .mem_be_o(fp_mem_be),
      .mem_wdata_o(fp_mem_wdata), .mem_rdata_i(fp_mem_rdata), .dbg_last_grant_o(fp_dbg)
   );

   // Behavioural memory: combinational read, byte-enabled write on the clock edge.
   assign mem_rdata = mem[mem_addr[9:2]];
   always @(posedge clk) begin
      if (mem_wen)
         for (int l = 0; l < 4; l++)
            if (mem_be[l]) mem[mem_addr[9:2]][8*l +: 8] <= mem_wdata[8*l +: 8];
   end

   // ---------------- driver tasks ----------------
   task automatic idle();
      req_valid = '0; req_we = '0; req_size = '0; req_unsigned = '0;
      req_addr = '0; req_wdata = '0;
   endtask

   task automatic set_req(input int p, input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd);
      req_valid[p] = 1'b1; req_we[p] = we; req_size[p] = sz;
      req_unsigned[p] = uns; req_addr[p] = addr; req_wdata[p] = wd;
   endtask

   task automatic do_reset();
      @(negedge clk); rst_n = 1'b0; idle();
      @(negedge clk); rst_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      set_req(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
      set_req(1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
      #1;
      n_checks++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
      n_checks++; if (mem_en !== 1'b0 || mem_wen !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got=%b%b exp=00", mem_en, mem_wen); end
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
      n_checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp got err=%b data=%h exp 0/0", rsp_err, rsp_rdata); end
      n_checks++; if (dbg_last !== 1'b1) begin n_fail++; $display("FAIL reset_last_grant got=%b exp=1", dbg_last); end
      @(negedge clk); rst_n = 1'b1; idle();
   endtask

   task automatic test_store_load();
      // sw 0xDEADBEEF -> 0x100 from port 0
      @(negedge clk); idle(); set_req(0, 1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF); #1;
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL sw_ready got=%b exp=01", req_ready); end
      n_checks++; if ({mem_en, mem_wen, mem_be} !== 6'b11_1111) begin n_fail++; $display("FAIL sw_mem got en=%b wen=%b be=%b exp 1 1 1111", mem_en, mem_wen, mem_be); end
      n_checks++; if (mem_addr !== 32'h100 || mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sw_addr_data got %h %h exp 00000100 deadbeef", mem_addr, mem_wdata); end
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL sw_rsp got v=%b e=%b d=%h exp 01 0 0", rsp_valid, rsp_err, rsp_rdata); end
      // sh 0xCAFE -> 0x106 from port 1
      @(negedge clk); idle(); set_req(1, 1'b1, 2'b01, 1'b0, 32'h106, 32'h1234CAFE); #1;
      n_checks++; if (req_ready !== 2'b10 || mem_be !== 4'b1100 || mem_wdata !== 32'hCAFECAFE || mem_addr !== 32'h104) begin n_fail++; $display("FAIL sh_mem got rdy=%b be=%b d=%h a=%h exp 10 1100 cafecafe 104", req_ready, mem_be, mem_wdata, mem_addr); end
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 2'b10) begin n_fail++; $display("FAIL sh_rsp_valid got=%b exp=10", rsp_valid); end
      // lw 0x100 from port 1
      @(negedge clk); idle(); set_req(1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0); #1;
      n_checks++; if (req_ready !== 2'b10 || {mem_en, mem_wen, mem_be} !== 6'b10_1111) begin n_fail++; $display("FAIL lw_mem got rdy=%b en=%b wen=%b be=%b exp 10 1 0 1111", req_ready, mem_en, mem_wen, mem_be); end
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rsp got v=%b e=%b d=%h exp 10 0 deadbeef", rsp_valid, rsp_err, rsp_rdata); end
      // lw 0x104 sees the half store
      @(negedge clk); idle(); set_req(0, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
      @(posedge clk); #1;
      n_checks++; if (rsp_rdata !== 32'hCAFE0000) begin n_fail++; $display("FAIL lw104_rsp got=%h exp=cafe0000", rsp_rdata); end
   endtask

   task automatic test_subword();
      logic [1:0]  sz  [6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
      logic        uns [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] adr [6] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101, 32'h100};
      logic [3:0]  ebe [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b0001};
      logic [31:0] exd [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80AD, 32'h0000BEEF, 32'hFFFFFFBE, 32'h000000EF};
      // sb 0x80 -> 0x103: word becomes 0x80ADBEEF
      @(negedge clk); idle(); set_req(0, 1'b1, 2'b00, 1'b0, 32'h103, 32'h00000080); #1;
      n_checks++; if (mem_be !== 4'b1000 || mem_wdata !== 32'h80808080 || mem_wen !== 1'b1) begin n_fail++; $display("FAIL sb_mem got be=%b d=%h wen=%b exp 1000 80808080 1", mem_be, mem_wdata, mem_wen); end
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); idle(); set_req(0, 1'b0, sz[i], uns[i], adr[i], 32'h0); #1;
         n_checks++; if (mem_be !== ebe[i] || mem_en !== 1'b1) begin n_fail++; $display("FAIL subload_be[%0d] got be=%b en=%b exp %b 1", i, mem_be, mem_en, ebe[i]); end
         @(posedge clk); #1;
         n_checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== exd[i]) begin n_fail++; $display("FAIL subload_rsp[%0d] got v=%b d=%h exp 01 %h", i, rsp_valid, rsp_rdata, exd[i]); end
      end
   endtask

   task automatic test_misaligned();
      logic        we  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [1:0]  sz  [4] = '{2'b01, 2'b01, 2'b10, 2'b11};
      logic [31:0] adr [4] = '{32'h101, 32'h101, 32'h102, 32'h100};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); idle(); set_req(1, we[i], sz[i], 1'b0, adr[i], 32'hFFFFFFFF); #1;
         n_checks++; if (req_ready !== 2'b10 || mem_en !== 1'b0 || mem_wen !== 1'b0 || mem_be !== 4'b0000) begin n_fail++; $display("FAIL misalign_mem[%0d] got rdy=%b en=%b wen=%b be=%b exp 10 0 0 0000", i, req_ready, mem_en, mem_wen, mem_be); end
         @(posedge clk); #1;
         n_checks++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL misalign_rsp[%0d] got v=%b e=%b d=%h exp 10 1 0", i, rsp_valid, rsp_err, rsp_rdata); end
      end
      @(negedge clk); idle(); set_req(1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
      @(posedge clk); #1;
      n_checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h80ADBEEF) begin n_fail++; $display("FAIL misalign_nowrite got e=%b d=%h exp 0 80adbeef", rsp_err, rsp_rdata); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_rdy;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); idle();
         set_req(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
         set_req(1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
         exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_grant[%0d] got=%b exp=%b", i, req_ready, exp_rdy); end
         @(posedge clk); #1;
         n_checks++; if (rsp_valid !== exp_rdy || rsp_rdata !== ((i % 2 == 0) ? 32'h80ADBEEF : 32'hCAFE0000)) begin n_fail++; $display("FAIL rr_rsp[%0d] got v=%b d=%h exp %b", i, rsp_valid, rsp_rdata, exp_rdy); end
      end
      @(negedge clk); idle(); #1;
      n_checks++; if (mem_en !== 1'b0 || mem_be !== 4'b0000 || req_ready !== 2'b00) begin n_fail++; $display("FAIL idle_mem got en=%b be=%b rdy=%b exp 0 0000 00", mem_en, mem_be, req_ready); end
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 2'b00 || rsp_rdata !== 32'hCAFE0000) begin n_fail++; $display("FAIL idle_rsp got v=%b d=%h exp 00 cafe0000", rsp_valid, rsp_rdata); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk); idle(); set_req(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0); #1;
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid_grant got=%b exp=01", req_ready); end
      @(posedge clk); #1;
      rst_n = 1'b0; idle(); #1;
      n_checks++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rstmid_rsp got=%b exp=00", rsp_valid); end
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      set_req(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
      set_req(1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
      #1;
      n_checks++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL rstmid_tie got=%b exp=01", req_ready); end
      @(posedge clk); #1;
      n_checks++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL rstmid_tie_rsp got=%b exp=01", rsp_valid); end
      @(negedge clk); idle();
   endtask

   task automatic test_fixed_prio();
      logic [1:0] exp_rdy;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk); fp_valid = 2'b11;
         exp_rdy = (i % 9 == 8) ? 2'b10 : 2'b01;
         #1;
         n_checks++; if (fp_ready !== exp_rdy) begin n_fail++; $display("FAIL fp_grant[%0d] got=%b exp=%b", i, fp_ready, exp_rdy); end
         @(posedge clk); #1;
         n_checks++; if (fp_rsp_valid !== exp_rdy) begin n_fail++; $display("FAIL fp_rsp[%0d] got=%b exp=%b", i, fp_rsp_valid, exp_rdy); end
      end
      @(negedge clk); fp_valid = 2'b00;
   endtask

   // ---------------- main sequence / report ----------------
   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 32'h0;
      rst_n = 1'b0; idle(); fp_valid = 2'b00;
      @(posedge clk);
      test_reset();
      test_store_load();
      test_subword();
      test_misaligned();
      test_round_robin();
      test_reset_mid();
      test_fixed_prio();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
